// File: rtl/assertion_ctrl_mc.sv
// Multi-channel assertion on/off controller: level-change detection on per-channel and global
// on/off strobes, registered pulses, per-channel active state and saturating disable counters.
module assertion_ctrl_mc #(
   parameter int              NCH          = 8,
   parameter int              CNT_W        = 16,
   parameter logic [NCH-1:0]  RESET_ACTIVE = {NCH{1'b1}},
   localparam int             RD_W         = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              fclk,
   input  logic              rst,
   input  logic              event_on,
   input  logic [NCH-1:0]    on_s,
   input  logic [NCH-1:0]    off_s,
   input  logic              global_on_s,
   input  logic              global_off_s,
   input  logic              clr_cnt,
   input  logic [RD_W-1:0]   rd_sel,
   output logic [NCH-1:0]    on_p,
   output logic [NCH-1:0]    off_p,
   output logic [NCH-1:0]    active,
   output logic [NCH-1:0]    conflict_p,
   output logic              conflict_sticky,
   output logic [CNT_W-1:0]  rd_data
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [NCH-1:0]   on_sd, off_sd;
   logic             gon_sd, goff_sd;
   logic [NCH-1:0]   on_ev, off_ev;
   logic             gon_ev, goff_ev;
   logic [NCH-1:0]   req_on, req_off, conflict;
   logic             g_on, g_off;
   logic [NCH-1:0]   on_nxt, off_nxt, conf_nxt;
   logic [CNT_W-1:0] cnt [NCH];
   logic [CNT_W-1:0] rd_mux;

   assign on_ev   = {NCH{event_on}} & (on_s ^ on_sd);
   assign off_ev  = {NCH{event_on}} & (off_s ^ off_sd);
   assign gon_ev  = event_on & (global_on_s ^ gon_sd);
   assign goff_ev = event_on & (global_off_s ^ goff_sd);

   // req_on/req_off already exclude the both-high case, so they never overlap a conflict
   assign req_on   = on_ev & on_s & ~off_s;
   assign req_off  = off_ev & off_s & ~on_s;
   assign conflict = on_ev & off_ev & on_s & off_s;
   assign g_on     = gon_ev & global_on_s & ~global_off_s;
   assign g_off    = goff_ev & global_off_s & ~global_on_s;

   always_comb begin
      on_nxt   = req_on;
      off_nxt  = req_off;
      conf_nxt = conflict;
      if (g_off) begin
         on_nxt   = '0;
         off_nxt  = '1;
         conf_nxt = '0;
      end else if (g_on) begin
         on_nxt   = '1;
         off_nxt  = '0;
         conf_nxt = '0;
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NCH; i++) begin
         if (NCH == 1 || 32'(rd_sel) == i) rd_mux = cnt[i];
      end
   end

   always_ff @(posedge fclk) begin
      if (rst) begin
         on_sd           <= '0;
         off_sd          <= '0;
         gon_sd          <= 1'b0;
         goff_sd         <= 1'b0;
         on_p            <= '0;
         off_p           <= '0;
         conflict_p      <= '0;
         active          <= RESET_ACTIVE;
         conflict_sticky <= 1'b0;
         rd_data         <= '0;
         for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      end else begin
         if (event_on) begin
            on_sd   <= on_s;
            off_sd  <= off_s;
            gon_sd  <= global_on_s;
            goff_sd <= global_off_s;
         end
         on_p       <= on_nxt;
         off_p      <= off_nxt;
         conflict_p <= conf_nxt;
         active     <= (active & ~off_nxt) | on_nxt;
         // a new conflict outranks a clear arriving in the same cycle
         conflict_sticky <= (|conf_nxt) | (conflict_sticky & ~clr_cnt);
         rd_data    <= rd_mux;
         for (int i = 0; i < NCH; i++) begin
            if (clr_cnt)
               cnt[i] <= '0;
            else if (off_nxt[i] && cnt[i] != CNT_MAX)
               cnt[i] <= cnt[i] + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_assertion_ctrl_mc.sv
// Randomized plus directed bench for assertion_ctrl_mc; a spec-level reference model feeds
// an expectation queue that a free-running monitor drains and compares every cycle.
module tb_assertion_ctrl_mc;

   localparam int             NCH   = 6;
   localparam int             CNT_W = 4;
   localparam int             RD_W  = 3;
   localparam logic [NCH-1:0] RA    = 6'b101101;
   localparam int             CMAX  = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [NCH-1:0]   on_p;
      logic [NCH-1:0]   off_p;
      logic [NCH-1:0]   active;
      logic [NCH-1:0]   conf;
      logic             sticky;
      logic [CNT_W-1:0] rd;
   } exp_t;

   logic fclk = 1'b0;
   logic rst, event_on, global_on_s, global_off_s, clr_cnt;
   logic [NCH-1:0] on_s, off_s;
   logic [RD_W-1:0] rd_sel;
   logic [NCH-1:0] on_p, off_p, active, conflict_p;
   logic conflict_sticky;
   logic [CNT_W-1:0] rd_data;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   exp_t exp_q[$];

   // reference model state
   bit m_on_prev[NCH];
   bit m_off_prev[NCH];
   bit m_gon_prev, m_goff_prev;
   bit m_active[NCH];
   int m_cnt[NCH];
   bit m_sticky;

   always #5 fclk = ~fclk;

   assertion_ctrl_mc #(.NCH(NCH), .CNT_W(CNT_W), .RESET_ACTIVE(RA)) dut (
      .fclk(fclk), .rst(rst), .event_on(event_on), .on_s(on_s), .off_s(off_s),
      .global_on_s(global_on_s), .global_off_s(global_off_s), .clr_cnt(clr_cnt),
      .rd_sel(rd_sel), .on_p(on_p), .off_p(off_p), .active(active),
      .conflict_p(conflict_p), .conflict_sticky(conflict_sticky), .rd_data(rd_data)
   );

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
      end
   endfunction

   // computes what the DUT must show after the coming rising edge, from the current inputs
   task automatic model_step();
      exp_t e;
      bit g_on, g_off, on_ev, off_ev, any_conf;
      int idx;
      e = '0;
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            m_on_prev[i] = 0; m_off_prev[i] = 0; m_cnt[i] = 0; m_active[i] = RA[i];
         end
         m_gon_prev = 0; m_goff_prev = 0; m_sticky = 0;
         e.active = RA;
      end else begin
         g_on  = event_on && (global_on_s != m_gon_prev) && global_on_s && !global_off_s;
         g_off = event_on && (global_off_s != m_goff_prev) && global_off_s && !global_on_s;
         any_conf = 0;
         for (int i = 0; i < NCH; i++) begin
            on_ev  = event_on && (on_s[i] != m_on_prev[i]);
            off_ev = event_on && (off_s[i] != m_off_prev[i]);
            if (g_off) e.off_p[i] = 1;
            else if (g_on) e.on_p[i] = 1;
            else if (on_ev && off_ev && on_s[i] && off_s[i]) e.conf[i] = 1;
            else if (on_ev && on_s[i] && !off_s[i]) e.on_p[i] = 1;
            else if (off_ev && off_s[i] && !on_s[i]) e.off_p[i] = 1;
            any_conf |= e.conf[i];
         end
         idx = int'(rd_sel);
         e.rd = (idx < NCH) ? CNT_W'(m_cnt[idx]) : '0;
         for (int i = 0; i < NCH; i++) begin
            if (e.on_p[i]) m_active[i] = 1;
            if (e.off_p[i]) m_active[i] = 0;
            if (clr_cnt) m_cnt[i] = 0;
            else if (e.off_p[i] && m_cnt[i] < CMAX) m_cnt[i]++;
            e.active[i] = m_active[i];
            if (event_on) begin
               m_on_prev[i] = on_s[i]; m_off_prev[i] = off_s[i];
            end
         end
         if (any_conf) m_sticky = 1;
         else if (clr_cnt) m_sticky = 0;
         e.sticky = m_sticky;
         if (event_on) begin
            m_gon_prev = global_on_s; m_goff_prev = global_off_s;
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic step(int n = 1);
      for (int k = 0; k < n; k++) begin
         model_step();
         @(negedge fclk);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge fclk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("on_p", 32'(on_p), 32'(e.on_p));
            chk("off_p", 32'(off_p), 32'(e.off_p));
            chk("active", 32'(active), 32'(e.active));
            chk("conflict_p", 32'(conflict_p), 32'(e.conf));
            chk("conflict_sticky", 32'(conflict_sticky), 32'(e.sticky));
            chk("rd_data", 32'(rd_data), 32'(e.rd));
         end
      end
   end

   initial begin : driver
      rst = 1; event_on = 0; on_s = '0; off_s = '0;
      global_on_s = 0; global_off_s = 0; clr_cnt = 0; rd_sel = '0;
      step(2);
      // on edge on channel 2
      rst = 0; event_on = 1; step();
      on_s[2] = 1; step(2);
      // off edge on channel 3, read its count, then drive it into saturation
      off_s[3] = 1; rd_sel = 3; step(3);
      for (int k = 0; k < 2 * CMAX + 6; k++) begin
         off_s[3] = ~off_s[3]; step();
      end
      step(2);
      // simultaneous on/off on channel 1, then clear
      on_s[1] = 1; off_s[1] = 1; step(2);
      clr_cnt = 1; step();
      clr_cnt = 0; step();
      // global off beats a channel on edge
      global_off_s = 1; on_s[0] = 1; step(2);
      global_off_s = 0; step();
      global_on_s = 1; step(2);
      global_on_s = 0; step();
      // clear coinciding with an increment and with a new conflict
      off_s[4] = 1; clr_cnt = 1; rd_sel = 4; step();
      clr_cnt = 0; step();
      on_s[5] = 1; off_s[5] = 1; clr_cnt = 1; step();
      clr_cnt = 0; step();
      on_s = '0; off_s = '0; step(2);
      // frozen sampling while event_on is low
      event_on = 0; on_s[4] = 1; step(3);
      event_on = 1; step(2);
      // reset right after an edge, then levels still high re-fire
      on_s[5] = 1; step();
      rst = 1; step();
      rst = 0; step(3);
      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         event_on = ($urandom_range(0, 9) < 8);
         on_s ^= NCH'($urandom() & $urandom());
         off_s ^= NCH'($urandom() & $urandom());
         if ($urandom_range(0, 9) == 0) global_on_s = ~global_on_s;
         if ($urandom_range(0, 11) == 0) global_off_s = ~global_off_s;
         clr_cnt = ($urandom_range(0, 29) == 0);
         rst = ($urandom_range(0, 149) == 0);
         rd_sel = RD_W'($urandom_range(0, 7));
         step();
      end
      rst = 0; step(2);
      @(posedge fclk);
      #2;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
